gfx_rom_arbiter: RTL and testbench

Shares one graphics-ROM memory channel between the TC0100SCN tile fetcher (port 0) and a second graphics requester such as the sprite engine (port 1). All three sides use toggle req/ack handshakes. Port 0 gets fixed priority because its fetch slots are raster-timed. A starvation guard bounds the wait on port 1. The block sits between the video chips and the SDRAM controller's ROM channel.

---
 rtl/gfx_rom_pkg.sv | 32 +++
 rtl/gfx_rom_port.sv | 38 +++
 rtl/gfx_rom_arbiter.sv | 150 +++++++++++++++
 tb/tb_gfx_rom_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_rom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gfx_rom_pkg
//  Description : Shared types and constants for the graphics-ROM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package gfx_rom_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Requester indices: tile fetcher and sprite engine
  localparam int PORT_SCN  = 0;
  localparam int PORT_OBJ  = 1;
  localparam int NUM_PORTS = 2;

  // One-hot grant encodings derived from the port indices
  localparam logic [NUM_PORTS-1:0] GNT_SCN  = 2'b01;
  localparam logic [NUM_PORTS-1:0] GNT_OBJ  = 2'b10;
  localparam logic [NUM_PORTS-1:0] GNT_NONE = 2'b00;

  // Saturating increment used by the starvation counter
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gfx_rom_port.sv
`default_nettype none
// ============================================================================
//  Module      : gfx_rom_port
//  Description : One requester side of the ROM arbiter: pending detect,
//                read-data holding register and ack toggle flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module gfx_rom_port (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_i,
  input  logic        complete_i,
  input  logic [31:0] mem_data_i,
  output logic        pending_o,
  output logic [31:0] data_o,
  output logic        ack_o
);

  logic        ack_q;
  logic [31:0] data_q;

  // Capture read data and toggle the ack together so data is valid with ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q  <= 1'b0;
      data_q <= 32'd0;
    end else if (complete_i) begin
      ack_q  <= ~ack_q;
      data_q <= mem_data_i;
    end
  end

  assign pending_o = req_i ^ ack_q;
  assign data_o    = data_q;
  assign ack_o     = ack_q;

endmodule
`default_nettype wire

// File: rtl/gfx_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gfx_rom_arbiter
//  Description : Two-port toggle-handshake arbiter onto one graphics-ROM
//                channel. Port 0 has fixed priority; a starvation counter
//                forces a port 1 grant after MAX_STARVE back-to-back port 0
//                grants while port 1 waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module gfx_rom_arbiter
  import gfx_rom_pkg::*;
#(
  parameter int                P0_AW      = 21,
  parameter int                P1_AW      = 21,
  parameter int                MEM_AW     = 24,
  parameter logic [MEM_AW-1:0] P0_BASE    = '0,
  parameter logic [MEM_AW-1:0] P1_BASE    = 24'h200000,
  parameter int                MAX_STARVE = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [P0_AW-1:0]  p0_address,
  input  logic              p0_req,
  output logic [31:0]       p0_data,
  output logic              p0_ack,
  input  logic [P1_AW-1:0]  p1_address,
  input  logic              p1_req,
  output logic [31:0]       p1_data,
  output logic              p1_ack,
  output logic [MEM_AW-1:0] mem_address,
  output logic              mem_req,
  input  logic [31:0]       mem_data,
  input  logic              mem_ack,
  output logic [1:0]        grant
);

  localparam logic [3:0] C_MAX_STARVE = 4'(MAX_STARVE);

  state_e                  state_q, state_d;
  logic [3:0]              starve_q, starve_d;
  logic                    mem_req_q, mem_req_d;
  logic [MEM_AW-1:0]       mem_addr_q, mem_addr_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;

  logic [NUM_PORTS-1:0]    w_pend;
  logic [NUM_PORTS-1:0]    w_complete;
  logic                    w_mem_busy;
  logic [MEM_AW-1:0]       w_addr_scn;
  logic [MEM_AW-1:0]       w_addr_obj;

  // Channel still owes an ack for the last toggle we (or a pre-reset us) issued
  assign w_mem_busy = (mem_ack != mem_req_q);

  // Physical addresses: base plus zero-extended port address, wrapping
  assign w_addr_scn = P0_BASE + MEM_AW'(p0_address);
  assign w_addr_obj = P1_BASE + MEM_AW'(p1_address);

  // Arbitration, issue and completion decisions
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    grant_d    = grant_q;
    w_complete = GNT_NONE;
    case (state_q)
      ST_IDLE: begin
        if (w_mem_busy) begin
          state_d = ST_DRAIN;
        end else if (w_pend[PORT_OBJ] && (starve_q == C_MAX_STARVE)) begin
          mem_addr_d = w_addr_obj;
          mem_req_d  = ~mem_req_q;
          grant_d    = GNT_OBJ;
          starve_d   = 4'd0;
          state_d    = ST_WAIT;
        end else if (w_pend[PORT_SCN]) begin
          mem_addr_d = w_addr_scn;
          mem_req_d  = ~mem_req_q;
          grant_d    = GNT_SCN;
          starve_d   = w_pend[PORT_OBJ] ? sat_inc(starve_q, C_MAX_STARVE) : 4'd0;
          state_d    = ST_WAIT;
        end else if (w_pend[PORT_OBJ]) begin
          mem_addr_d = w_addr_obj;
          mem_req_d  = ~mem_req_q;
          grant_d    = GNT_OBJ;
          starve_d   = 4'd0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!w_mem_busy) begin
          w_complete = grant_q;
          grant_d    = GNT_NONE;
          state_d    = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!w_mem_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      starve_q   <= 4'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      grant_q    <= GNT_NONE;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      grant_q    <= grant_d;
    end
  end

  gfx_rom_port u_port_scn (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (p0_req),
    .complete_i (w_complete[PORT_SCN]),
    .mem_data_i (mem_data),
    .pending_o  (w_pend[PORT_SCN]),
    .data_o     (p0_data),
    .ack_o      (p0_ack)
  );

  gfx_rom_port u_port_obj (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (p1_req),
    .complete_i (w_complete[PORT_OBJ]),
    .mem_data_i (mem_data),
    .pending_o  (w_pend[PORT_OBJ]),
    .data_o     (p1_data),
    .ack_o      (p1_ack)
  );

  assign mem_address = mem_addr_q;
  assign mem_req     = mem_req_q;
  assign grant       = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_gfx_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gfx_rom_arbiter
//  Description : Scoreboard bench for gfx_rom_arbiter with a toggle-handshake
//                memory channel model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gfx_rom_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        reset_n;
  logic [20:0] p0_address, p1_address;
  logic        p0_req, p1_req;
  logic [31:0] p0_data, p1_data;
  logic        p0_ack, p1_ack;
  logic [23:0] mem_address;
  logic        mem_req;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic [1:0]  grant;

  // Wrap-case DUT signals
  logic [20:0] x_p0_address, x_p1_address;
  logic        x_p0_req, x_p1_req;
  logic [31:0] x_p0_data, x_p1_data;
  logic        x_p0_ack, x_p1_ack;
  logic [23:0] x_mem_address;
  logic        x_mem_req;
  logic [31:0] x_mem_data;
  logic        x_mem_ack;
  logic [1:0]  x_grant;

  gfx_rom_arbiter #(
    .P0_AW(21), .P1_AW(21), .MEM_AW(24),
    .P0_BASE(24'h000000), .P1_BASE(24'h200000), .MAX_STARVE(3)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .p0_address(p0_address), .p0_req(p0_req), .p0_data(p0_data), .p0_ack(p0_ack),
    .p1_address(p1_address), .p1_req(p1_req), .p1_data(p1_data), .p1_ack(p1_ack),
    .mem_address(mem_address), .mem_req(mem_req), .mem_data(mem_data),
    .mem_ack(mem_ack), .grant(grant)
  );

  gfx_rom_arbiter #(
    .P0_AW(21), .P1_AW(21), .MEM_AW(24),
    .P0_BASE(24'h000000), .P1_BASE(24'hF00000), .MAX_STARVE(3)
  ) u_dut_wrap (
    .clk(clk), .reset_n(reset_n),
    .p0_address(x_p0_address), .p0_req(x_p0_req), .p0_data(x_p0_data), .p0_ack(x_p0_ack),
    .p1_address(x_p1_address), .p1_req(x_p1_req), .p1_data(x_p1_data), .p1_ack(x_p1_ack),
    .mem_address(x_mem_address), .mem_req(x_mem_req), .mem_data(x_mem_data),
    .mem_ack(x_mem_ack), .grant(x_grant)
  );

  // Counters and bookkeeping
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int issue_cyc  = 0;
  int p0_ack_cyc = 0;
  int p1_ack_cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [23:0] addr;
    logic [1:0]  gnt;
  } issue_t;

  typedef struct {
    int          wait_n;
    logic [31:0] data;
    logic [1:0]  gnt;
  } rsp_t;

  issue_t      iss_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] p0_q[$];
  logic [31:0] p1_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
  endtask

  // Monitor: compare every issue and every completion against the scoreboard
  logic   prv_req, prv_a0, prv_a1;
  issue_t mon_e;
  logic [31:0] mon_d;
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_req !== prv_req) begin
        issue_cyc = cyc;
        if (iss_q.size() == 0) fail_evt("spurious_issue");
        else begin
          mon_e = iss_q.pop_front();
          chk("issue_addr", 32'(mem_address), 32'(mon_e.addr));
          chk("issue_grant", 32'(grant), 32'(mon_e.gnt));
        end
      end
      if (p0_ack !== prv_a0) begin
        p0_ack_cyc = cyc;
        if (p0_q.size() == 0) fail_evt("spurious_p0_ack");
        else begin
          mon_d = p0_q.pop_front();
          chk("p0_data", p0_data, mon_d);
        end
      end
      if (p1_ack !== prv_a1) begin
        p1_ack_cyc = cyc;
        if (p1_q.size() == 0) fail_evt("spurious_p1_ack");
        else begin
          mon_d = p1_q.pop_front();
          chk("p1_data", p1_data, mon_d);
        end
      end
    end
    prv_req = mem_req;
    prv_a0  = p0_ack;
    prv_a1  = p1_ack;
  end

  // Memory channel model: acks wait_n+1 edges after it sees the req toggle,
  // presenting drifting junk data until the ack cycle
  logic mem_hold = 1'b0;
  logic mbusy    = 1'b0;
  logic gnt_bad  = 1'b0;
  int   mcnt     = 0;
  rsp_t cur;
  always @(posedge clk) begin
    #1;
    if (reset_n && !mem_hold) begin
      if (!mbusy && (mem_req != mem_ack)) begin
        if (rsp_q.size() == 0) begin
          fail_evt("no_rsp_queued");
          mem_ack = mem_req;
        end else begin
          cur      = rsp_q.pop_front();
          mcnt     = cur.wait_n;
          mbusy    = 1'b1;
          gnt_bad  = (grant !== cur.gnt);
          mem_data = 32'hBAD0_0000;
        end
      end else if (mbusy) begin
        if (grant !== cur.gnt) gnt_bad = 1'b1;
        if (mcnt == 0) begin
          mem_data = cur.data;
          mem_ack  = ~mem_ack;
          mbusy    = 1'b0;
          chk("grant_held", 32'(gnt_bad), 32'd0);
        end else begin
          mcnt--;
          mem_data = mem_data + 32'd1;
        end
      end
    end
  end

  // Wrap DUT channel: acks on the first edge after issue
  always @(posedge clk) begin
    #1;
    if (reset_n && (x_mem_req != x_mem_ack)) begin
      x_mem_data = 32'h0BAD_F00D;
      x_mem_ack  = x_mem_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input logic [23:0] a, input logic [1:0] g, input logic [31:0] d, input int w);
    issue_t e;
    rsp_t   r;
    e.addr = a; e.gnt = g;
    r.wait_n = w; r.data = d; r.gnt = g;
    iss_q.push_back(e);
    rsp_q.push_back(r);
    if (g == 2'b01) p0_q.push_back(d);
    else            p1_q.push_back(d);
  endtask

  task automatic wait_quiet(input string nm, input int max);
    int k = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0 || p0_q.size() != 0 ||
            p1_q.size() != 0 || mbusy || (p0_req != p0_ack) || (p1_req != p1_ack)) && k < max) begin
      step();
      k++;
    end
    if (k >= max) fail_evt({nm, "_timeout"});
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int t0;

  initial begin
    reset_n = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0; p0_address = '0; p1_address = '0;
    mem_ack = 1'b0; mem_data = 32'd0;
    x_p0_req = 1'b0; x_p1_req = 1'b0; x_p0_address = '0; x_p1_address = '0;
    x_mem_ack = 1'b0; x_mem_data = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_p0_ack", 32'(p0_ack), 32'd0);
    chk("rst_p1_ack", 32'(p1_ack), 32'd0);
    chk("rst_p0_data", p0_data, 32'd0);
    chk("rst_p1_data", p1_data, 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    reset_n = 1'b1;
    step();
    step();

    // Single port 0 read, zero-wait: issue at t+1, ack at t+3
    t0 = cyc;
    expect_rd(24'h000123, 2'b01, 32'hDEADBEEF, 0);
    p0_address = 21'h00123; p0_req = ~p0_req;
    wait_quiet("p0_single", 50);
    chk("p0_issue_latency", 32'(issue_cyc - t0), 32'd1);
    chk("p0_ack_latency", 32'(p0_ack_cyc - t0), 32'd3);

    // Port 1 with base offset
    expect_rd(24'h3FFFFF, 2'b10, 32'h12345678, 0);
    p1_address = 21'h1FFFFF; p1_req = ~p1_req;
    wait_quiet("p1_base", 50);
    chk("p0_data_hold", p0_data, 32'hDEADBEEF);

    // Simultaneous toggle with starve at 0: port 0 first
    expect_rd(24'h000ABC, 2'b01, 32'h11111111, 0);
    expect_rd(24'h200010, 2'b10, 32'h22222222, 0);
    p0_address = 21'h00ABC; p0_req = ~p0_req;
    p1_address = 21'h00010; p1_req = ~p1_req;
    wait_quiet("simul", 80);
    chk("simul_p1_after_p0", 32'(p1_ack_cyc > p0_ack_cyc), 32'd1);

    // Starvation guard: grants 0,0,0,1,0
    expect_rd(24'h000100, 2'b01, 32'hA0000000, 0);
    expect_rd(24'h000101, 2'b01, 32'hA0000001, 0);
    expect_rd(24'h000102, 2'b01, 32'hA0000002, 0);
    expect_rd(24'h200020, 2'b10, 32'hB0000001, 0);
    expect_rd(24'h000103, 2'b01, 32'hA0000003, 0);
    p0_address = 21'h00100; p0_req = ~p0_req;
    p1_address = 21'h00020; p1_req = ~p1_req;
    for (int k = 1; k <= 3; k++) begin
      int b = 0;
      while ((p0_ack != p0_req) && b < 50) begin
        step();
        b++;
      end
      if (b >= 50) fail_evt("starve_rereq_timeout");
      p0_address = 21'h00100 + 21'(k);
      p0_req = ~p0_req;
    end
    wait_quiet("starve", 100);

    // Wait-state channel: ack 7 cycles after the req toggle
    t0 = cyc;
    expect_rd(24'h01ABCD, 2'b01, 32'hCAFEF00D, 6);
    p0_address = 21'h1ABCD; p0_req = ~p0_req;
    wait_quiet("wait_state", 80);
    chk("wait_ack_latency", 32'(p0_ack_cyc - t0), 32'd9);

    // Address wrap with P1_BASE = 0xF00000
    x_p1_address = 21'h1FFFFF; x_p1_req = 1'b1;
    begin
      int b = 0;
      while (x_mem_req != 1'b1 && b < 20) begin step(); b++; end
      if (b >= 20) fail_evt("wrap_issue_timeout");
      chk("wrap_mem_address", 32'(x_mem_address), 32'h000FFFFF);
      chk("wrap_grant", 32'(x_grant), 32'd2);
      b = 0;
      while (x_p1_ack != 1'b1 && b < 20) begin step(); b++; end
      if (b >= 20) fail_evt("wrap_ack_timeout");
      chk("wrap_p1_data", x_p1_data, 32'h0BADF00D);
    end

    // Reset drain: channel still owes an ack after reset release
    mem_hold = 1'b1;
    reset_n = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0; x_p1_req = 1'b0;
    mem_ack = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    step();
    expect_rd(24'h000777, 2'b01, 32'h77777777, 0);
    p0_address = 21'h00777; p0_req = ~p0_req;
    repeat (8) step();
    chk("drain_no_issue", 32'(mem_req), 32'd0);
    chk("drain_no_ack", 32'(p0_ack), 32'd0);
    chk("drain_grant_idle", 32'(grant), 32'd0);
    mem_ack  = 1'b0;
    mem_hold = 1'b0;
    wait_quiet("drain", 50);
    chk("drain_p0_ack", 32'(p0_ack), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
